// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit with busy stall and done pulse
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
  state_t state;
  logic [2:0] op;
  logic [WIDTH-1:0] a, b;
  logic sign_a, sign_b;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0] cnt;
  logic is_div, sgn_a_op, sgn_b_op, sa, sb, div_zero, div_ovf;
  logic [WIDTH-1:0] ma, mb, special, q_fix, r_fix;
  logic [WIDTH:0] msum, rtrial, rdiff;
  logic [2*WIDTH-1:0] p_fix;
  // prod holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    is_div   = op[2];
    sgn_a_op = is_div ? ~op[0] : (op[1:0] != 2'b11);
    sgn_b_op = is_div ? ~op[0] : ~op[1];
    sa       = sgn_a_op & a[WIDTH-1];
    sb       = sgn_b_op & b[WIDTH-1];
    ma       = sa ? -a : a;
    mb       = sb ? -b : b;
    div_zero = is_div && (b == '0);
    div_ovf  = is_div && !op[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    special  = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
    msum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? a : {WIDTH{1'b0}})};
    rtrial   = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    rdiff    = rtrial - {1'b0, b};
    p_fix    = (sign_a ^ sign_b) ? -prod : prod;
    q_fix    = (sign_a ^ sign_b) ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    r_fix    = sign_a ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op     <= '0;
      a      <= '0;
      b      <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      prod   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      Result <= '0;
    end else if (kill && state != IDLE) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !kill) begin
          op    <= funct3;
          a     <= SrcA;
          b     <= SrcB;
          busy  <= 1'b1;
          state <= PREP;
        end
        PREP: begin
          sign_a <= sa;
          sign_b <= sb;
          a      <= ma;
          b      <= mb;
          cnt    <= '0;
          prod   <= {{WIDTH{1'b0}}, (is_div ? ma : mb)};
          if (div_zero || div_ovf) begin
            Result <= special;
            done   <= 1'b1;
            state  <= DONE;
          end else state <= ITER;
        end
        ITER: begin
          // restoring divide keeps the shifted remainder when the trial subtract borrows
          prod <= is_div ? {(rdiff[WIDTH] ? rtrial[WIDTH-1:0] : rdiff[WIDTH-1:0]), prod[WIDTH-2:0], ~rdiff[WIDTH]}
                         : {msum, prod[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          Result <= is_div ? (op[1] ? r_fix : q_fix) : (op == 3'b000 ? p_fix[WIDTH-1:0] : p_fix[2*WIDTH-1:WIDTH]);
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed checks of muldiv_sequencer results, timing, kill and reset
module tb_muldiv_sequencer;
  logic clk, reset, start, kill, busy, done;
  logic [2:0] funct3;
  logic [31:0] SrcA, SrcB, Result;
  int tests, fails;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done), .Result(Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller is 1ns after an edge with the unit idle; that cycle is cycle 0.
  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] expv, input int exp_cyc, input bit pulse_in_done);
    int cyc;
    logic bok;
    funct3 = f;
    SrcA = a;
    SrcB = b;
    start = 1'b1;
    step();
    start = 1'b0;
    SrcA = 32'h1234_5678;
    SrcB = 32'h9abc_def0;
    cyc = 1;
    bok = 1'b1;
    while (!done && cyc < 100) begin
      bok &= busy;
      step();
      cyc++;
    end
    bok &= busy;
    chk({tag, " done_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, " result"}, Result, expv);
    chk({tag, " busy_window"}, {31'b0, bok}, 32'd1);
    if (pulse_in_done) begin
      funct3 = 3'b000;
      start = 1'b1;
    end
    step();
    start = 1'b0;
    chk({tag, " busy_after"}, {31'b0, busy}, 32'd0);
    chk({tag, " done_after"}, {31'b0, done}, 32'd0);
    if (pulse_in_done) begin
      step();
      chk({tag, " done_start_ignored"}, {31'b0, busy}, 32'd0);
    end
  endtask

  initial begin
    logic seen_done;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    start = 1'b0;
    kill = 1'b0;
    funct3 = 3'b000;
    SrcA = '0;
    SrcB = '0;
    #12;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset result", Result, 32'd0);
    reset = 1'b0;
    step();
    run("MUL", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, 1'b0);
    run("MULH", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35, 1'b0);
    run("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 1'b0);
    run("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, 1'b0);
    run("DIV", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, 1'b0);
    run("REM", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, 1'b0);
    run("DIVU", 3'b101, 32'd100, 32'd7, 32'd14, 35, 1'b0);
    run("REMU", 3'b111, 32'd100, 32'd7, 32'd2, 35, 1'b0);
    run("DIVU0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
    run("DIVOVF", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b0);
    run("REMOVF", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2, 1'b0);
    run("REM0", 3'b110, 32'd5, 32'd0, 32'd5, 2, 1'b0);
    // kill a MUL in cycle 10
    funct3 = 3'b000;
    SrcA = 32'd3;
    SrcB = 32'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    seen_done = 1'b0;
    for (int c = 1; c < 10; c++) begin
      seen_done |= done;
      step();
    end
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill busy_c11", {31'b0, busy}, 32'd0);
    for (int c = 0; c < 40; c++) begin
      seen_done |= done;
      step();
    end
    chk("kill no_done", {31'b0, seen_done}, 32'd0);
    chk("kill result_kept", Result, 32'd5);
    // start and kill together in idle
    funct3 = 3'b101;
    SrcA = 32'd9;
    SrcB = 32'd3;
    start = 1'b1;
    kill = 1'b1;
    step();
    start = 1'b0;
    kill = 1'b0;
    chk("startkill busy", {31'b0, busy}, 32'd0);
    step();
    chk("startkill busy2", {31'b0, busy}, 32'd0);
    run("AFTERKILL", 3'b101, 32'd100, 32'd7, 32'd14, 35, 1'b0);
    // asynchronous reset in cycle 20
    funct3 = 3'b000;
    SrcA = 32'd6;
    SrcB = 32'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 20; c++) step();
    chk("pre_reset busy", {31'b0, busy}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("async busy", {31'b0, busy}, 32'd0);
    chk("async done", {31'b0, done}, 32'd0);
    chk("async result", Result, 32'd0);
    #2;
    reset = 1'b0;
    step();
    run("POSTRESET", 3'b000, 32'd6, 32'd7, 32'd42, 35, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the RV32M multiply/divide instructions. It sits beside the ALU in the execute stage and receives the same `SrcA`/`SrcB` operands and the instruction `funct3`. It runs an iterative shift-add multiply or restoring divide. While it runs, it holds `busy` high to stall PC and register-file writeback. When the result is ready, it pulses `done` with the 32-bit result.

## Interface
- `WIDTH`, 32: operand and result width; the iteration count equals `WIDTH`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  decoder flags an M-extension instruction (opcode 0110011, funct7 0000001); sampled only in IDLE.
- `kill`  in  1  synchronous abort (pipeline flush/trap); takes priority over `start`.
- `funct3`  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `SrcA`  in  WIDTH  rs1 operand (dividend / multiplicand).
- `SrcB`  in  WIDTH  rs2 operand (divisor / multiplier).
- `busy`  out  1  high whenever state ≠ IDLE; drives the core stall.
- `done`  out  1  one-cycle pulse; `Result` is valid in the same cycle.
- `Result`  out  WIDTH  final result; held from `done` until the next accepted `start`.

## Operation
- **States:** IDLE, PREP, ITER, FIX, DONE. Reset enters IDLE with `busy`=0, `done`=0, `Result`=0, iteration counter=0 and all internal registers zeroed.
- **Accepting a start:** in IDLE, `start`=1 and `kill`=0 latches `funct3`, `SrcA` and `SrcB`, then moves to PREP. `start` is ignored in every other state.
- **PREP:**
  - Records the operand signs. Signed treatment applies per operation: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats only A as signed; MULHU/DIVU/REMU treat neither as signed.
  - Replaces each signed operand with its magnitude and clears the accumulator and counter.
  - Special divide cases jump straight to DONE with a fixed result:
    - Divide by zero (`SrcB`=0): DIV/DIVU return 0xFFFFFFFF; REM/REMU return `SrcA`.
    - Signed overflow (DIV/REM with `SrcA`=0x80000000, `SrcB`=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
  - All other operations go to ITER.
- **ITER:** one step per cycle for `WIDTH` cycles, with the counter running 0..WIDTH-1.
  - Multiply: shift-add into a 2×WIDTH product register.
  - Divide: restoring step. Shift the remainder left, trial-subtract the divisor, and set the quotient bit on no-borrow.
  - After the step at counter = WIDTH-1, go to FIX.
- **FIX:**
  - Product is negated when the operand signs differ (signed modes only).
  - Quotient is negated when the dividend and divisor signs differ; remainder takes the dividend's sign.
  - Result selection: MUL = low half; MULH/MULHSU/MULHU = high half; DIV/DIVU = quotient; REM/REMU = remainder.
  - Latch the selected value into `Result`, then go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- **Kill:** `kill`=1 in any non-IDLE state returns to IDLE on the next edge. No `done` is produced and `Result` keeps its old value. `kill` in IDLE has no effect and blocks a simultaneous `start`.
- **Arithmetic:** all arithmetic is modulo 2^WIDTH (the product register is 2×WIDTH). Negating 0x80000000 yields 0x80000000, handled as an unsigned magnitude.

## Timing
- Cycle numbering: cycle 0 is the cycle in which `start` is accepted.
- **Normal operation:** PREP in cycle 1, ITER in cycles 2..WIDTH+1, FIX in cycle WIDTH+2, DONE in cycle WIDTH+3. For WIDTH=32, `done` is high in cycle 35.
- **Special divide cases:** `done` is high in cycle 2.
- **Busy window:** `busy` is high in cycles 1 through the DONE cycle inclusive, and low again in the following cycle.
- **Back-to-back:** the earliest next `start` is accepted the cycle after DONE.
- **Asynchronous reset:** `reset` clears all outputs immediately, mid-operation included, independent of `clk`. Operation resumes in IDLE at the first edge after deassertion.
- All outputs are registered; none depend combinationally on the inputs.

## Test plan
- **MUL:** 7 × 0xFFFFFFFD (−3) → `Result`=0xFFFFFFEB; `done` in cycle 35 only; `busy` high in cycles 1–35.
- **High-half multiplies:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Signed divide and remainder:**
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM −7 / 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 / 7 → 2.
- **Special cases:**
  - DIVU 5 / 0 → 0xFFFFFFFF with `done` in cycle 2.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- **Kill and start interaction:**
  - `kill` in cycle 10 of a MUL: `busy` low in cycle 11, no `done`, `Result` unchanged.
  - `start` + `kill` together in IDLE: no accept.
  - A new `start` afterwards completes normally.
- **Reset mid-operation:** assert `reset` between edges in cycle 20 → `busy`/`done`/`Result` are 0 immediately. A `start` after release runs the full 35 cycles. A `start` pulsed during DONE is ignored.
